jtcps1_vram_arb: RTL and testbench

- Shares the 68000 bus and the VRAM DMA SDRAM port between two DMA requesters: the OBJ table copier and the palette copier.
- Raises the CPU bus request, waits for bus grant, then grants one requester at a time.
- Muxes the granted requester's VRAM address onto the SDRAM DMA port and keeps grant until that requester drops its request.
- Sits between jtcps1_obj, jtcps1_colmix and the 68000 bus controller, inside jtcps1_video.

---
 rtl/jtcps1_vram_arb.sv | 184 ++++++++++++++++++
 tb/tb_jtcps1_vram_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps1_vram_arb.sv
// jtcps1_vram_arb
// Shares the 68000 bus and the VRAM DMA SDRAM port between two DMA
// requesters: the OBJ table copier and the palette copier. The arbiter
// requests the CPU bus, waits for the acknowledge, then grants one
// requester at a time. The granted requester keeps the port until it
// drops its request. Ties are broken round-robin.
//
// Ports
//   clk, rstn          system clock, asynchronous active-low reset
//   pxl_cen            pixel clock enable, only paces the busack timeout
//   HB                 horizontal blank (new grants gated by it if HBONLY=1)
//   br_obj/bg_obj      OBJ DMA request / grant, obj_addr its word address
//   br_pal/bg_pal      palette DMA request / grant, pal_addr its word address
//   busreq/busack      68000 bus request / acknowledge
//   vram_addr/vram_cs  SDRAM DMA word address and chip select
//   vram_clr           one-cycle cache invalidate at the start of each grant
//   ack_err            sticky flag, set when busack does not arrive in time
module jtcps1_vram_arb #(
  parameter int ACKTO  = 8,
  parameter bit HBONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pxl_cen,
  input  logic        HB,
  input  logic        br_obj,
  output logic        bg_obj,
  input  logic [17:1] obj_addr,
  input  logic        br_pal,
  output logic        bg_pal,
  input  logic [17:1] pal_addr,
  output logic        busreq,
  input  logic        busack,
  output logic [17:1] vram_addr,
  output logic        vram_cs,
  output logic        vram_clr,
  output logic        ack_err
);

  localparam int CW = $clog2(ACKTO + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACKTO > 0 ? ACKTO - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, WAITACK, GRANT, HANDOVER, RELEASE
  } state_t;

  // Owner encoding: 0 = OBJ, 1 = PAL.
  state_t          state_q, state_d;
  logic            busreq_q, busreq_d;
  logic            bg_q, bg_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            clr_q, clr_d;
  logic            err_q, err_d;
  logic            regrant_q, regrant_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic hb_ok, own_br, oth_br;

  always_comb begin
    hb_ok  = !HBONLY || HB;
    own_br = owner_q ? br_pal : br_obj;
    oth_br = owner_q ? br_obj : br_pal;

    state_d   = state_q;
    busreq_d  = busreq_q;
    bg_d      = bg_q;
    owner_d   = owner_q;
    last_d    = last_q;
    clr_d     = 1'b0;
    err_d     = err_q;
    regrant_d = regrant_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if ((br_obj || br_pal) && hb_ok) begin
          busreq_d  = 1'b1;
          cnt_d     = '0;
          regrant_d = 1'b0;
          state_d   = WAITACK;
        end
      end
      WAITACK: begin
        if (busack) begin
          // After a bus loss the interrupted owner resumes if still asking.
          state_d   = GRANT;
          bg_d      = 1'b1;
          clr_d     = 1'b1;
          regrant_d = 1'b0;
          if (regrant_q && own_br) owner_d = owner_q;
          else if (br_obj && br_pal) owner_d = ~last_q;
          else if (br_obj) owner_d = 1'b0;
          else if (br_pal) owner_d = 1'b1;
          else begin
            state_d  = RELEASE;
            bg_d     = 1'b0;
            clr_d    = 1'b0;
            busreq_d = 1'b0;
          end
        end else if (pxl_cen) begin
          if (ACKTO > 0 && cnt_q == CNT_LAST) begin
            err_d     = 1'b1;
            busreq_d  = 1'b0;
            regrant_d = 1'b0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GRANT: begin
        if (!busack) begin
          bg_d      = 1'b0;
          regrant_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAITACK;
        end else if (!own_br) begin
          bg_d   = 1'b0;
          last_d = owner_q;
          if (oth_br && hb_ok) begin
            state_d = HANDOVER;
          end else begin
            busreq_d = 1'b0;
            state_d  = RELEASE;
          end
        end
      end
      HANDOVER: begin
        // owner_q still names the previous owner here.
        if (!busack) begin
          cnt_d   = '0;
          state_d = WAITACK;
        end else if (oth_br) begin
          owner_d = ~owner_q;
          bg_d    = 1'b1;
          clr_d   = 1'b1;
          state_d = GRANT;
        end else begin
          busreq_d = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!busack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      busreq_q  <= 1'b0;
      bg_q      <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      regrant_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busreq_q  <= busreq_d;
      bg_q      <= bg_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      clr_q     <= clr_d;
      err_q     <= err_d;
      regrant_q <= regrant_d;
      cnt_q     <= cnt_d;
    end
  end

  // Grant is masked by busack so a lost bus drops the port in the same cycle.
  assign vram_cs   = bg_q & busack;
  assign bg_obj    = vram_cs & ~owner_q;
  assign bg_pal    = vram_cs & owner_q;
  assign vram_addr = vram_cs ? (owner_q ? pal_addr : obj_addr) : '0;
  assign vram_clr  = clr_q;
  assign busreq    = busreq_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
module tb_jtcps1_vram_arb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pxl_cen = 1'b1;
  logic        HB = 1'b0;
  logic        br_obj = 1'b0, br_pal = 1'b0, busack = 1'b0;
  logic [17:1] obj_addr = '0, pal_addr = '0;
  logic        bg_obj, bg_pal, busreq, vram_cs, vram_clr, ack_err;
  logic [17:1] vram_addr;

  // Second instance with HBONLY=1
  logic        h_hb = 1'b0, h_br_pal = 1'b0, h_busack = 1'b0;
  logic        h_br_obj = 1'b0, h_cen = 1'b1;
  logic [17:1] h_obj_addr = '0, h_pal_addr = 17'h0_1234;
  logic        h_bg_obj, h_bg_pal, h_busreq, h_vram_cs, h_vram_clr, h_ack_err;
  logic [17:1] h_vram_addr;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;
  bit last_owner;  // 0 = OBJ, 1 = PAL

  always #5 clk = ~clk;

  jtcps1_vram_arb #(.ACKTO(8), .HBONLY(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .HB(HB),
    .br_obj(br_obj), .bg_obj(bg_obj), .obj_addr(obj_addr),
    .br_pal(br_pal), .bg_pal(bg_pal), .pal_addr(pal_addr),
    .busreq(busreq), .busack(busack),
    .vram_addr(vram_addr), .vram_cs(vram_cs), .vram_clr(vram_clr),
    .ack_err(ack_err)
  );

  jtcps1_vram_arb #(.ACKTO(8), .HBONLY(1'b1)) u_hb (
    .clk(clk), .rstn(rstn), .pxl_cen(h_cen), .HB(h_hb),
    .br_obj(h_br_obj), .bg_obj(h_bg_obj), .obj_addr(h_obj_addr),
    .br_pal(h_br_pal), .bg_pal(h_bg_pal), .pal_addr(h_pal_addr),
    .busreq(h_busreq), .busack(h_busack),
    .vram_addr(h_vram_addr), .vram_cs(h_vram_cs), .vram_clr(h_vram_clr),
    .ack_err(h_ack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Properties that hold on every cycle, whatever the scenario.
  always @(negedge clk) begin
    if (inv_en) begin
      check("excl_bg", {31'd0, bg_obj & bg_pal}, 32'd0);
      check("bg_wo_ack", {31'd0, (bg_obj | bg_pal) & ~busack}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: a lone requester wins; on a tie the one that did not
  // own last time wins.
  function automatic bit pick(input bit ro, input bit rp);
    if (ro && rp) return ~last_owner;
    return ro ? 1'b0 : 1'b1;
  endfunction

  task automatic check_grant(input bit own, input bit clr);
    check("bg_obj", {31'd0, bg_obj}, {31'd0, ~own});
    check("bg_pal", {31'd0, bg_pal}, {31'd0, own});
    check("vram_cs", {31'd0, vram_cs}, 32'd1);
    check("vram_clr", {31'd0, vram_clr}, {31'd0, clr});
    check("vram_addr", {15'd0, vram_addr}, {15'd0, own ? pal_addr : obj_addr});
  endtask

  task automatic check_no_bg(input string tag);
    check(tag, {29'd0, bg_obj, bg_pal, vram_cs}, 32'd0);
  endtask

  task automatic hold_owner(input bit own, input bit loss);
    int len;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) begin
      tick();
      obj_addr = 17'($urandom);
      pal_addr = 17'($urandom);
      #1;
      check_grant(own, 1'b0);
      if (loss && i == 0) begin
        busack = 1'b0;
        #1;
        check_no_bg("loss_drop");
        tick();
        check("loss_busreq", {31'd0, busreq}, 32'd1);
        repeat (3) begin
          tick();
          check_no_bg("loss_wait");
        end
        busack = 1'b1;
        tick();
        check_grant(own, 1'b1);
      end
    end
  endtask

  task automatic drop_br(input bit own);
    if (own) br_pal = 1'b0;
    else br_obj = 1'b0;
  endtask

  task automatic run_grant(input bit ro, input bit rp, input bit loss);
    bit own, oth;
    int dly;
    own = pick(ro, rp);
    oth = ~own;
    obj_addr = 17'($urandom);
    pal_addr = 17'($urandom);
    br_obj = ro;
    br_pal = rp;
    tick();
    check("busreq_up", {31'd0, busreq}, 32'd1);
    check_no_bg("bg_before_ack");
    dly = $urandom_range(0, 5);
    repeat (dly) begin
      tick();
      check("busreq_wait", {31'd0, busreq}, 32'd1);
      check("clr_wait", {31'd0, vram_clr}, 32'd0);
      check_no_bg("bg_wait");
    end
    busack = 1'b1;
    tick();
    check_grant(own, 1'b1);
    hold_owner(own, loss);
    drop_br(own);
    last_owner = own;
    tick();
    check_no_bg("bg_drop");
    if (oth ? rp : ro) begin
      check("handover_busreq", {31'd0, busreq}, 32'd1);
      tick();
      check_grant(oth, 1'b1);
      hold_owner(oth, 1'b0);
      drop_br(oth);
      last_owner = oth;
      tick();
      check_no_bg("bg_drop2");
    end
    check("release_busreq", {31'd0, busreq}, 32'd0);
    busack = 1'b0;
    tick();
    tick();
    check("idle_busreq", {31'd0, busreq}, 32'd0);
  endtask

  initial begin
    int n;
    bit ro, rp;
    last_owner = 1'b1;
    #12;
    check("rst_outs", {26'd0, busreq, bg_obj, bg_pal, vram_cs, vram_clr, ack_err}, 32'd0);
    check("rst_addr", {15'd0, vram_addr}, 32'd0);
    tick();
    rstn = 1'b1;
    inv_en = 1'b1;
    tick();

    // Directed round-robin sequence
    run_grant(1'b1, 1'b1, 1'b0);  // OBJ then PAL
    run_grant(1'b1, 1'b1, 1'b0);  // OBJ again after PAL
    run_grant(1'b1, 1'b0, 1'b0);  // lone OBJ
    run_grant(1'b1, 1'b1, 1'b0);  // PAL first after OBJ
    run_grant(1'b0, 1'b1, 1'b1);  // PAL with bus loss

    // Random scenarios
    for (int k = 0; k < 24; k++) begin
      ro = 1'($urandom);
      rp = 1'($urandom);
      if (!ro && !rp) ro = 1'b1;
      run_grant(ro, rp, ($urandom_range(0, 3) == 0));
    end

    // Busack timeout with a randomly paced pixel enable
    check("err_before", {31'd0, ack_err}, 32'd0);
    br_obj = 1'b1;
    tick();
    check("to_busreq", {31'd0, busreq}, 32'd1);
    n = 0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      pxl_cen = 1'($urandom);
      tick();
      if (pxl_cen) n++;
      check("to_err", {31'd0, ack_err}, {31'd0, n >= 8});
      check("to_busreq", {31'd0, busreq}, {31'd0, n < 8});
      check_no_bg("to_bg");
    end
    check("to_bound", n, 8);
    br_obj = 1'b0;
    pxl_cen = 1'b1;
    tick();
    check("to_idle", {31'd0, busreq}, 32'd0);
    check("to_sticky", {31'd0, ack_err}, 32'd1);

    // Asynchronous reset in the middle of a grant
    br_pal = 1'b1;
    pal_addr = 17'h1_5a5a;
    tick();
    busack = 1'b1;
    tick();
    check_grant(pick(1'b0, 1'b1), 1'b1);
    #2;
    inv_en = 1'b0;
    rstn = 1'b0;
    #1;
    check("rstmid_outs", {26'd0, busreq, bg_obj, bg_pal, vram_cs, vram_clr, ack_err}, 32'd0);
    check("rstmid_addr", {15'd0, vram_addr}, 32'd0);
    br_pal = 1'b0;
    busack = 1'b0;
    last_owner = 1'b1;
    tick();
    rstn = 1'b1;
    inv_en = 1'b1;
    tick();
    run_grant(1'b1, 1'b1, 1'b0);

    // HB-gated instance: no bus request until blanking
    h_br_pal = 1'b1;
    repeat ($urandom_range(2, 6)) begin
      tick();
      check("hb_hold", {31'd0, h_busreq}, 32'd0);
    end
    h_hb = 1'b1;
    tick();
    check("hb_busreq", {31'd0, h_busreq}, 32'd1);
    h_busack = 1'b1;
    tick();
    check("hb_bg", {30'd0, h_bg_pal, h_vram_clr}, 32'd3);
    h_hb = 1'b0;
    tick();
    check("hb_cont", {30'd0, h_bg_pal, h_vram_cs}, 32'd3);
    check("hb_addr", {15'd0, h_vram_addr}, {15'd0, h_pal_addr});
    h_br_pal = 1'b0;
    tick();
    check("hb_drop", {30'd0, h_bg_pal, h_busreq}, 32'd0);
    h_busack = 1'b0;
    tick();

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
